// File: rtl/servant_mem_arb3.sv
// servant_mem_arb3: three-way round-robin Wishbone arbiter (ibus, dbus, dma) in front of servant_ram.
// Define SERVANT_ARB_TIMEOUT_EN to add the stalled-RAM abort watchdog and the sticky o_timeout flag.
module servant_mem_arb3 #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [AW-1:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic          o_ibus_ack,
  input  logic [AW-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic          o_dbus_ack,
  input  logic [AW-1:0] i_dma_adr,
  input  logic [31:0]   i_dma_dat,
  input  logic [3:0]    i_dma_sel,
  input  logic          i_dma_we,
  input  logic          i_dma_cyc,
  output logic          o_dma_ack,
  output logic [31:0]   o_rdt,
  output logic [AW-1:0] o_mem_adr,
  output logic [31:0]   o_mem_dat,
  output logic [3:0]    o_mem_sel,
  output logic          o_mem_we,
  output logic          o_mem_cyc,
  input  logic [31:0]   i_mem_rdt,
  input  logic          i_mem_ack,
  output logic [2:0]    o_grant,
  output logic          o_timeout
);

  // state | meaning
  // IDLE  | no grant held; arbitrate among pending cyc requests
  // BUSY  | one requester owns the RAM port until ack, abort or timeout

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [2:0] G_IBUS = 3'b001;
  localparam logic [2:0] G_DBUS = 3'b010;
  localparam logic [2:0] G_DMA  = 3'b100;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("servant_mem_arb3: TIMEOUT must be at least 1");
  end

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [2:0] last_q, last_d;
  logic [2:0] req;
  logic [2:0] pick;
  logic       gnt_cyc;
  logic       busy;
  logic       to_hit;

  assign req  = {i_dma_cyc, i_dbus_cyc, i_ibus_cyc};
  assign busy = (state_q == BUSY);

  // Round robin: search starts at the requester just after the last one served.
  always_comb begin
    pick = 3'b000;
    case (last_q)
      G_IBUS: begin
        if (req[1])      pick = G_DBUS;
        else if (req[2]) pick = G_DMA;
        else if (req[0]) pick = G_IBUS;
      end
      G_DBUS: begin
        if (req[2])      pick = G_DMA;
        else if (req[0]) pick = G_IBUS;
        else if (req[1]) pick = G_DBUS;
      end
      default: begin
        if (req[0])      pick = G_IBUS;
        else if (req[1]) pick = G_DBUS;
        else if (req[2]) pick = G_DMA;
      end
    endcase
  end

  always_comb begin
    o_mem_adr = '0;
    o_mem_dat = '0;
    o_mem_sel = '0;
    o_mem_we  = 1'b0;
    gnt_cyc   = 1'b0;
    case (grant_q)
      G_IBUS: begin
        o_mem_adr = i_ibus_adr;
        o_mem_sel = 4'hf;
        gnt_cyc   = i_ibus_cyc;
      end
      G_DBUS: begin
        o_mem_adr = i_dbus_adr;
        o_mem_dat = i_dbus_dat;
        o_mem_sel = i_dbus_sel;
        o_mem_we  = i_dbus_we;
        gnt_cyc   = i_dbus_cyc;
      end
      G_DMA: begin
        o_mem_adr = i_dma_adr;
        o_mem_dat = i_dma_dat;
        o_mem_sel = i_dma_sel;
        o_mem_we  = i_dma_we;
        gnt_cyc   = i_dma_cyc;
      end
      default: ;
    endcase
  end

  assign o_mem_cyc = busy & gnt_cyc;
  assign o_grant   = grant_q;
  assign o_rdt     = to_hit ? 32'h0 : i_mem_rdt;

`ifdef SERVANT_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  logic [TW-1:0] tmr_q;
  logic          timeout_q;

  assign to_hit    = busy & gnt_cyc & ~i_mem_ack & (tmr_q == TW'(TIMEOUT));
  assign o_timeout = timeout_q;

  // Held at zero while idle so every grant starts a fresh count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (!busy)
        tmr_q <= '0;
      else if (!i_mem_ack)
        tmr_q <= tmr_q + 1'b1;
      if (to_hit)
        timeout_q <= 1'b1;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    o_ibus_ack = 1'b0;
    o_dbus_ack = 1'b0;
    o_dma_ack  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick != 3'b000) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!gnt_cyc) begin
          // Requester gave up: release without ack and without moving the rotation.
          grant_d = '0;
          state_d = IDLE;
        end else if (i_mem_ack || to_hit) begin
          o_ibus_ack = grant_q[0];
          o_dbus_ack = grant_q[1];
          o_dma_ack  = grant_q[2];
          last_d     = grant_q;
          grant_d    = '0;
          state_d    = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= G_DMA;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_servant_mem_arb3.sv
// tb_servant_mem_arb3: vector table for the RAM-port mux plus hand sequences for arbitration corners.
// Covers the SERVANT_ARB_TIMEOUT_EN build and the default build.
module tb_servant_mem_arb3;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_ibus_adr;
  logic        i_ibus_cyc;
  logic        o_ibus_ack;
  logic [31:0] i_dbus_adr;
  logic [31:0] i_dbus_dat;
  logic [3:0]  i_dbus_sel;
  logic        i_dbus_we;
  logic        i_dbus_cyc;
  logic        o_dbus_ack;
  logic [31:0] i_dma_adr;
  logic [31:0] i_dma_dat;
  logic [3:0]  i_dma_sel;
  logic        i_dma_we;
  logic        i_dma_cyc;
  logic        o_dma_ack;
  logic [31:0] o_rdt;
  logic [31:0] o_mem_adr;
  logic [31:0] o_mem_dat;
  logic [3:0]  o_mem_sel;
  logic        o_mem_we;
  logic        o_mem_cyc;
  logic [31:0] i_mem_rdt;
  logic        i_mem_ack;
  logic [2:0]  o_grant;
  logic        o_timeout;

  always #5 i_clk = ~i_clk;

  servant_mem_arb3 #(.AW(32), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc), .o_ibus_ack(o_ibus_ack),
    .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
    .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc), .o_dbus_ack(o_dbus_ack),
    .i_dma_adr(i_dma_adr), .i_dma_dat(i_dma_dat), .i_dma_sel(i_dma_sel),
    .i_dma_we(i_dma_we), .i_dma_cyc(i_dma_cyc), .o_dma_ack(o_dma_ack),
    .o_rdt(o_rdt), .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat), .o_mem_sel(o_mem_sel),
    .o_mem_we(o_mem_we), .o_mem_cyc(o_mem_cyc), .i_mem_rdt(i_mem_rdt), .i_mem_ack(i_mem_ack),
    .o_grant(o_grant), .o_timeout(o_timeout)
  );

  typedef struct {
    int unsigned who;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] rdt;
    logic [2:0]  eg;
    logic [31:0] edat;
    logic [3:0]  esel;
    logic        ewe;
  } vec_t;

  typedef struct {
    logic [2:0] grant;
    int         cyc;
  } sb_t;

  int  checks   = 0;
  int  failures = 0;
  sb_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] acks();
    return {o_dma_ack, o_dbus_ack, o_ibus_ack};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Non-zero junk on every idle port so the mux must really select.
  task automatic idle_inputs();
    i_ibus_cyc = 1'b0;
    i_dbus_cyc = 1'b0;
    i_dma_cyc  = 1'b0;
    i_mem_ack  = 1'b0;
    i_ibus_adr = 32'h1111_1110;
    i_dbus_adr = 32'h2222_2220;
    i_dbus_dat = 32'h3333_3333;
    i_dbus_sel = 4'h0;
    i_dbus_we  = 1'b1;
    i_dma_adr  = 32'h4444_4440;
    i_dma_dat  = 32'h5555_5555;
    i_dma_sel  = 4'h0;
    i_dma_we   = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_mem_rdt = 32'h0;
    i_rst_n   = 1'b0;
    step();
    step();
    i_rst_n = 1'b1;
    #1;
  endtask

  // 1-cycle RAM: acks in the second cycle it sees o_mem_cyc; pops scoreboard on each requester ack.
  task automatic run_ram(input string tag, input int budget);
    logic        pend;
    logic [31:0] exp_rdt;
    sb_t         e;
    pend = 1'b0;
    for (int c = 0; c < budget && sb.size() > 0; c++) begin
      step();
      i_mem_ack = pend & o_mem_cyc;
      exp_rdt   = 32'hBEEF_0000 + 32'(c);
      i_mem_rdt = exp_rdt;
      #1;
      if (i_mem_ack) begin
        e = sb.pop_front();
        chk({tag, "_ack"}, 32'(acks()), 32'(e.grant));
        chk({tag, "_rdt"}, o_rdt, exp_rdt);
        if (e.cyc >= 0) chk({tag, "_cycle"}, 32'(c), 32'(e.cyc));
      end
      pend = o_mem_cyc & ~i_mem_ack;
    end
    if (sb.size() != 0) begin
      chk({tag, "_budget_left"}, 32'(sb.size()), 32'h0);
      sb.delete();
    end
    step();
    i_mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    sb_t  e;
    vt[0] = '{who:1, adr:32'h0000_0100, dat:32'hA5A5_0001, sel:4'b0011, we:1'b1, rdt:32'h0000_0000,
              eg:3'b010, edat:32'hA5A5_0001, esel:4'b0011, ewe:1'b1};
    vt[1] = '{who:0, adr:32'h0000_0040, dat:32'h0, sel:4'h0, we:1'b0, rdt:32'h1357_9BDF,
              eg:3'b001, edat:32'h0, esel:4'hf, ewe:1'b0};
    vt[2] = '{who:2, adr:32'h0000_2000, dat:32'hDEAD_BEEF, sel:4'hf, we:1'b1, rdt:32'h0,
              eg:3'b100, edat:32'hDEAD_BEEF, esel:4'hf, ewe:1'b1};
    vt[3] = '{who:2, adr:32'h0000_3004, dat:32'h1234_5678, sel:4'b0100, we:1'b0, rdt:32'hCAFE_F00D,
              eg:3'b100, edat:32'h1234_5678, esel:4'b0100, ewe:1'b0};
    vt[4] = '{who:1, adr:32'hFFFF_FFFC, dat:32'h0, sel:4'b1000, we:1'b0, rdt:32'h89AB_CDEF,
              eg:3'b010, edat:32'h0, esel:4'b1000, ewe:1'b0};
    vt[5] = '{who:0, adr:32'h0000_0000, dat:32'h0, sel:4'h0, we:1'b0, rdt:32'hFFFF_FFFF,
              eg:3'b001, edat:32'h0, esel:4'hf, ewe:1'b0};

    // Reset values
    do_reset();
    chk("rst_grant", 32'(o_grant), 32'h0);
    chk("rst_acks", 32'(acks()), 32'h0);
    chk("rst_mem_cyc", 32'(o_mem_cyc), 32'h0);
    chk("rst_mem_we", 32'(o_mem_we), 32'h0);
    chk("rst_mem_adr", o_mem_adr, 32'h0);
    chk("rst_mem_dat", o_mem_dat, 32'h0);
    chk("rst_mem_sel", 32'(o_mem_sel), 32'h0);
    chk("rst_timeout", 32'(o_timeout), 32'h0);

    // Single-requester transfers through the RAM mux
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      case (vt[i].who)
        0: begin
          i_ibus_adr = vt[i].adr;
          i_ibus_cyc = 1'b1;
        end
        1: begin
          i_dbus_adr = vt[i].adr; i_dbus_dat = vt[i].dat;
          i_dbus_sel = vt[i].sel; i_dbus_we = vt[i].we; i_dbus_cyc = 1'b1;
        end
        default: begin
          i_dma_adr = vt[i].adr; i_dma_dat = vt[i].dat;
          i_dma_sel = vt[i].sel; i_dma_we = vt[i].we; i_dma_cyc = 1'b1;
        end
      endcase
      #1;
      chk($sformatf("vec%0d_idle_grant", i), 32'(o_grant), 32'h0);
      step();
      #1;
      chk($sformatf("vec%0d_grant", i), 32'(o_grant), 32'(vt[i].eg));
      chk($sformatf("vec%0d_adr", i), o_mem_adr, vt[i].adr);
      chk($sformatf("vec%0d_dat", i), o_mem_dat, vt[i].edat);
      chk($sformatf("vec%0d_sel", i), 32'(o_mem_sel), 32'(vt[i].esel));
      chk($sformatf("vec%0d_we", i), 32'(o_mem_we), 32'(vt[i].ewe));
      chk($sformatf("vec%0d_cyc", i), 32'(o_mem_cyc), 32'h1);
      chk($sformatf("vec%0d_early_ack", i), 32'(acks()), 32'h0);
      sb.push_back('{grant: vt[i].eg, cyc: -1});
      i_mem_rdt = vt[i].rdt;
      i_mem_ack = 1'b1;
      #1;
      e = sb.pop_front();
      chk($sformatf("vec%0d_ack", i), 32'(acks()), 32'(e.grant));
      chk($sformatf("vec%0d_rdt", i), o_rdt, vt[i].rdt);
      step();
      idle_inputs();
      #1;
      chk($sformatf("vec%0d_done_grant", i), 32'(o_grant), 32'h0);
      chk($sformatf("vec%0d_single_ack", i), 32'(acks()), 32'h0);
    end

    // All three at once: ibus, dbus, dma with one IDLE cycle between grants
    do_reset();
    i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1; i_dma_cyc = 1'b1;
    sb.push_back('{grant: 3'b001, cyc: 1});
    sb.push_back('{grant: 3'b010, cyc: 4});
    sb.push_back('{grant: 3'b100, cyc: 7});
    run_ram("t1", 30);
    idle_inputs();

    // DMA held continuously against a constantly requesting ibus: strict alternation
    do_reset();
    i_ibus_cyc = 1'b1; i_dma_cyc = 1'b1;
    for (int k = 0; k < 6; k++) sb.push_back('{grant: (k % 2 == 0) ? 3'b001 : 3'b100, cyc: -1});
    run_ram("t3", 40);
    idle_inputs();

    // Reset in BUSY: port released at once, rotation restarts at ibus
    do_reset();
    i_ibus_cyc = 1'b1;
    sb.push_back('{grant: 3'b001, cyc: -1});
    run_ram("t4_pre", 10);
    idle_inputs();
    i_dbus_cyc = 1'b1;
    step();
    #1;
    chk("t4_busy_grant", 32'(o_grant), 32'h2);
    i_mem_ack = 1'b1;
    i_rst_n   = 1'b0;
    #1;
    chk("t4_rst_mem_cyc", 32'(o_mem_cyc), 32'h0);
    chk("t4_rst_grant", 32'(o_grant), 32'h0);
    chk("t4_rst_acks", 32'(acks()), 32'h0);
    step();
    i_mem_ack  = 1'b0;
    i_ibus_cyc = 1'b1;
    i_rst_n    = 1'b1;
    step();
    #1;
    chk("t4_first_grant", 32'(o_grant), 32'h1);
    i_mem_ack = 1'b1;
    #1;
    chk("t4_first_ack", 32'(acks()), 32'h1);
    step();
    idle_inputs();

    // Stray ack in IDLE, then granted dbus abandons its cycle
    do_reset();
    i_mem_ack = 1'b1;
    #1;
    chk("t5_stray_ack", 32'(acks()), 32'h0);
    step();
    chk("t5_stray_grant", 32'(o_grant), 32'h0);
    i_mem_ack  = 1'b0;
    i_dbus_cyc = 1'b1;
    step();
    #1;
    chk("t5_dbus_grant", 32'(o_grant), 32'h2);
    i_dbus_cyc = 1'b0;
    i_mem_ack  = 1'b1;
    #1;
    chk("t5_drop_ack", 32'(acks()), 32'h0);
    chk("t5_drop_mem_cyc", 32'(o_mem_cyc), 32'h0);
    step();
    i_mem_ack = 1'b0;
    #1;
    chk("t5_abort_idle", 32'(o_grant), 32'h0);
    i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1; i_dma_cyc = 1'b1;
    step();
    #1;
    chk("t5_last_kept", 32'(o_grant), 32'h1);
    idle_inputs();
    step();
    #1;
    chk("t5_cleanup_grant", 32'(o_grant), 32'h0);

`ifdef SERVANT_ARB_TIMEOUT_EN
    // RAM never answers a DMA read: 15 silent BUSY cycles, abort ack on the 16th
    do_reset();
    i_dma_cyc = 1'b1;
    i_dma_we  = 1'b0;
    i_dma_adr = 32'h0000_8000;
    i_mem_rdt = 32'hFFFF_FFFF;
    step();
    for (int k = 1; k <= 15; k++) begin
      #1;
      chk($sformatf("t6_wait%0d_ack", k), 32'(acks()), 32'h0);
      step();
    end
    #1;
    chk("t6_to_ack", 32'(acks()), 32'h4);
    chk("t6_to_rdt", o_rdt, 32'h0);
    step();
    #1;
    chk("t6_timeout_flag", 32'(o_timeout), 32'h1);
    chk("t6_to_idle", 32'(o_grant), 32'h0);
    idle_inputs();
    i_ibus_cyc = 1'b1;
    sb.push_back('{grant: 3'b001, cyc: -1});
    run_ram("t6_after", 10);
    idle_inputs();
    #1;
    chk("t6_timeout_sticky", 32'(o_timeout), 32'h1);
`else
    // Without the watchdog a silent RAM simply holds the grant
    do_reset();
    i_dma_cyc = 1'b1;
    for (int k = 0; k < 20; k++) step();
    #1;
    chk("t6_hold_grant", 32'(o_grant), 32'h4);
    chk("t6_hold_acks", 32'(acks()), 32'h0);
    chk("t6_no_timeout", 32'(o_timeout), 32'h0);
    sb.push_back('{grant: 3'b100, cyc: -1});
    run_ram("t6_late", 10);
    idle_inputs();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
